// File: rtl/ch_debouncer_pkg.sv
// Shared constants and types for the parking-spot input conditioner.
package ch_debouncer_pkg;

    // Board-level defaults (spot count, clock rate, debounce window).
    localparam int N_VAGAS     = 8;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 1 ms sample tick; stability window expressed in ticks.
    localparam int DEF_TICK_DIV     = CLK_HZ / 1000;
    localparam int DEF_STABLE_TICKS = DEBOUNCE_MS;

    // One channel's conditioned outputs, grouped for the top-level fan-out.
    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
    } cell_out_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ch_debounce_cell.sv
// One channel: stability counter, accepted level and edge pulses.
import ch_debouncer_pkg::*;

module ch_debounce_cell #(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = 4
) (
    input  logic clk_internal,
    input  logic rst_n,
    input  logic tick,
    input  logic sync_in,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    // Any agreement restarts the window; a change is accepted only after
    // STABLE_TICKS consecutive mismatching ticks. Pulses share the clean edge.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_in == clean) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    clean <= sync_in;
                    cnt   <= '0;
                    rise  <= sync_in;
                    fall  <= ~sync_in;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ch_debouncer.sv
// Parking-spot switch conditioner: synchronise, debounce, emit edge events.
import ch_debouncer_pkg::*;

module ch_debouncer #(
    parameter int N_CH         = N_VAGAS,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = 4
) (
    input  logic            clk_internal,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ch_raw,
    output logic [N_CH-1:0] ch_clean,
    output logic [N_CH-1:0] occ_pulse,
    output logic [N_CH-1:0] free_pulse,
    output logic            any_change
);

    localparam int PW = cnt_bits(TICK_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    logic [1:0][N_CH-1:0] sync_pipe;
    logic [N_CH-1:0]      ch_sync;
    logic [PW-1:0]        psc;
    logic                 tick;
    cell_out_t [N_CH-1:0] cell_q;

    // Two-flop synchroniser; stage 1 is the settled copy of ch_raw.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[0], ch_raw};
    end

    assign ch_sync = sync_pipe[1];

    // Shared sample-tick prescaler, wraps at TICK_DIV-1.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n)            psc <= '0;
        else if (psc == PSC_LAST) psc <= '0;
        else                   psc <= psc + PW'(1);
    end

    assign tick = (psc == PSC_LAST);

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_cell
            ch_debounce_cell #(
                .STABLE_TICKS (STABLE_TICKS),
                .CNT_W        (CNT_W)
            ) u_cell (
                .clk_internal (clk_internal),
                .rst_n        (rst_n),
                .tick         (tick),
                .sync_in      (ch_sync[i]),
                .clean        (cell_q[i].clean),
                .rise         (cell_q[i].rise),
                .fall         (cell_q[i].fall)
            );
            assign ch_clean[i]   = cell_q[i].clean;
            assign occ_pulse[i]  = cell_q[i].rise;
            assign free_pulse[i] = cell_q[i].fall;
        end
    endgenerate

    // Single "something changed" strobe for downstream refresh.
    always_comb begin
        any_change = |(occ_pulse | free_pulse);
    end

endmodule

// File: tb/tb_ch_debouncer.sv
// Directed bench for ch_debouncer with a short tick and window.
module tb_ch_debouncer;

    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int LMIN = 2 + (ST - 1) * TD + 1;  // 11
    localparam int LMAX = 2 + ST * TD;            // 14

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ch_raw = 8'h00;
    logic [7:0] ch_clean, occ_pulse, free_pulse;
    logic       any_change;

    int vecs = 0;
    int errs = 0;

    ch_debouncer #(.N_CH(8), .TICK_DIV(TD), .STABLE_TICKS(ST), .CNT_W(4)) dut (
        .clk_internal (clk),
        .rst_n        (rst_n),
        .ch_raw       (ch_raw),
        .ch_clean     (ch_clean),
        .occ_pulse    (occ_pulse),
        .free_pulse   (free_pulse),
        .any_change   (any_change)
    );

    always #5 clk = ~clk;

    // Advance to the first cycle showing any_change, within a cycle budget.
    task automatic wait_evt(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (any_change) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n; bit ok; bit bad;
        rst_n = 1'b0; ch_raw = 8'hFF; bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ch_clean !== 8'h00 || occ_pulse !== 8'h00 || free_pulse !== 8'h00 || any_change !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad) begin errs++; $display("FAIL reset_hold: clean=%h occ=%h free=%h any=%b, want all 0", ch_clean, occ_pulse, free_pulse, any_change); end
        rst_n = 1'b1;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || n < LMIN || n > LMAX || occ_pulse !== 8'hFF || free_pulse !== 8'h00 || ch_clean !== 8'hFF) begin
            errs++; $display("FAIL reset_release: ok=%b lat=%0d clean=%h occ=%h free=%h, want lat %0d..%0d clean=ff occ=ff free=00", ok, n, ch_clean, occ_pulse, free_pulse, LMIN, LMAX);
        end
        @(negedge clk);
        vecs++;
        if (occ_pulse !== 8'h00 || any_change !== 1'b0 || ch_clean !== 8'hFF) begin
            errs++; $display("FAIL reset_pulse_width: occ=%h any=%b clean=%h, want occ=00 any=0 clean=ff", occ_pulse, any_change, ch_clean);
        end
        ch_raw = 8'h00;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || n < LMIN || n > LMAX || free_pulse !== 8'hFF || occ_pulse !== 8'h00 || ch_clean !== 8'h00) begin
            errs++; $display("FAIL all_free: ok=%b lat=%0d clean=%h occ=%h free=%h, want clean=00 occ=00 free=ff", ok, n, ch_clean, occ_pulse, free_pulse);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clean_step();
        int n; bit ok;
        ch_raw[2] = 1'b1;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || n < LMIN || n > LMAX || occ_pulse !== 8'h04 || free_pulse !== 8'h00 || any_change !== 1'b1 || ch_clean !== 8'h04) begin
            errs++; $display("FAIL clean_step: ok=%b lat=%0d clean=%h occ=%h free=%h any=%b, want clean=04 occ=04 free=00 any=1", ok, n, ch_clean, occ_pulse, free_pulse, any_change);
        end
        @(negedge clk);
        vecs++;
        if (occ_pulse !== 8'h00 || any_change !== 1'b0) begin
            errs++; $display("FAIL step_pulse_width: occ=%h any=%b, want occ=00 any=0", occ_pulse, any_change);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit bad = 1'b0;
        ch_raw[5] = 1'b1;
        repeat (8) begin @(negedge clk); if (any_change) bad = 1'b1; end
        ch_raw[5] = 1'b0;
        repeat (30) begin @(negedge clk); if (any_change || ch_clean !== 8'h04) bad = 1'b1; end
        vecs++;
        if (bad) begin errs++; $display("FAIL glitch: clean=%h any seen, want clean=04 and no pulse", ch_clean); end
    endtask

    task automatic test_bounce();
        int n; bit ok; bit bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            ch_raw[0] = ((t / 3) % 2 == 0);
            @(negedge clk);
            if (any_change) bad = 1'b1;
        end
        vecs++;
        if (bad) begin errs++; $display("FAIL bounce_quiet: pulse during bounce, clean=%h want 04", ch_clean); end
        ch_raw[0] = 1'b1;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || n > LMAX || occ_pulse !== 8'h01 || free_pulse !== 8'h00 || ch_clean !== 8'h05) begin
            errs++; $display("FAIL bounce_settle: ok=%b lat=%0d clean=%h occ=%h free=%h, want lat<=%0d clean=05 occ=01", ok, n, ch_clean, occ_pulse, free_pulse, LMAX);
        end
        bad = 1'b0;
        repeat (20) begin @(negedge clk); if (any_change) bad = 1'b1; end
        vecs++;
        if (bad) begin errs++; $display("FAIL bounce_single: extra pulse, clean=%h want 05", ch_clean); end
    endtask

    task automatic test_simultaneous();
        int n; bit ok;
        ch_raw = 8'h0F;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || occ_pulse !== 8'h0A || free_pulse !== 8'h00 || ch_clean !== 8'h0F) begin
            errs++; $display("FAIL sim_setup: ok=%b clean=%h occ=%h free=%h, want clean=0f occ=0a free=00", ok, ch_clean, occ_pulse, free_pulse);
        end
        repeat (4) @(negedge clk);
        ch_raw = 8'hF0;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || n < LMIN || n > LMAX || occ_pulse !== 8'hF0 || free_pulse !== 8'h0F || ch_clean !== 8'hF0) begin
            errs++; $display("FAIL simultaneous: ok=%b lat=%0d clean=%h occ=%h free=%h, want clean=f0 occ=f0 free=0f", ok, n, ch_clean, occ_pulse, free_pulse);
        end
        @(negedge clk);
        vecs++;
        if (any_change !== 1'b0) begin errs++; $display("FAIL sim_pulse_width: any=%b want 0", any_change); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit bad = 1'b0;
        ch_raw = 8'h70;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || free_pulse !== 8'h80 || occ_pulse !== 8'h00 || ch_clean !== 8'h70) begin
            errs++; $display("FAIL mid_setup: ok=%b clean=%h occ=%h free=%h, want clean=70 free=80", ok, ch_clean, occ_pulse, free_pulse);
        end
        repeat (4) @(negedge clk);
        ch_raw[7] = 1'b1;
        repeat (6) begin @(negedge clk); if (any_change) bad = 1'b1; end
        rst_n = 1'b0; ch_raw[7] = 1'b0;
        #1;
        vecs++;
        if (ch_clean !== 8'h00 || occ_pulse !== 8'h00 || free_pulse !== 8'h00) begin
            errs++; $display("FAIL mid_async_reset: clean=%h occ=%h free=%h, want all 0", ch_clean, occ_pulse, free_pulse);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_evt(LMAX + 4, n, ok);
        vecs++;
        if (!ok || occ_pulse !== 8'h70 || free_pulse !== 8'h00 || ch_clean !== 8'h70) begin
            errs++; $display("FAIL mid_release: ok=%b clean=%h occ=%h free=%h, want clean=70 occ=70", ok, ch_clean, occ_pulse, free_pulse);
        end
        repeat (30) begin @(negedge clk); if (any_change || ch_clean[7] !== 1'b0) bad = 1'b1; end
        vecs++;
        if (bad) begin errs++; $display("FAIL mid_no_pulse7: clean=%h, want bit7=0 and no stray pulse", ch_clean); end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
